// File: rtl/video_pkg.sv
// video_pkg: shared types, pattern encodings and bar colour table for the video pattern source
package video_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  typedef enum logic [1:0] {PAT_BARS, PAT_RAMP, PAT_CHECKER, PAT_SOLID} pattern_t;
  typedef logic [31:0] pixel_t;
  typedef logic [63:0] beat_t;
  localparam logic [7:0][23:0] BAR_COLORS = {
    24'h000000, 24'h0000FF, 24'hFF0000, 24'hFF00FF,
    24'h00FF00, 24'h00FFFF, 24'hFFFF00, 24'hFFFFFF
  };
  localparam logic [15:0] CHECK_MASK = 16'h0020;
  function automatic pixel_t to_pixel(input logic [23:0] rgb);
    return {8'h00, rgb};
  endfunction
endpackage

// File: rtl/video_pattern_pixel.sv
// video_pattern_pixel: combinational RGB generator for one pixel of the selected test pattern
module video_pattern_pixel import video_pkg::*; #(
  parameter int H_ACTIVE = 640
) (
  input  logic [15:0] p,
  input  logic [15:0] y,
  input  pattern_t    pattern,
  input  logic [23:0] solid_color,
  output logic [23:0] rgb
);
  logic [2:0] k;
  logic       check;
  always_comb begin
    k = 3'((32'(p) * 32'd8) / 32'(H_ACTIVE));
    check = |((p ^ y) & CHECK_MASK);
    rgb = pattern == PAT_BARS    ? BAR_COLORS[k] :
          pattern == PAT_RAMP    ? {3{p[7:0]}} :
          pattern == PAT_CHECKER ? (check ? 24'hFFFFFF : 24'h000000) :
                                   solid_color;
  end
endmodule

// File: rtl/video_pattern_source.sv
// video_pattern_source: AXI4-Stream test pattern generator, two pixels per beat, framed by IDLE/ACTIVE/GAP
module video_pattern_source import video_pkg::*; #(
  parameter int H_ACTIVE  = 640,
  parameter int V_ACTIVE  = 480,
  parameter int FRAME_GAP = 16
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        aclken,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  input  logic [23:0] solid_color,
  output logic [63:0] m_axis_video_tdata,
  output logic        m_axis_video_tvalid,
  input  logic        m_axis_video_tready,
  output logic        m_axis_video_tuser,
  output logic        m_axis_video_tlast,
  output logic [15:0] frame_count,
  output logic        busy
);
  localparam int BW = $clog2(H_ACTIVE / 2);
  localparam int YW = $clog2(V_ACTIVE);
  localparam int GW = $clog2(FRAME_GAP + 1);
  state_t          state, state_n;
  pattern_t        pat, pat_n;
  logic [23:0]     solid, solid_n;
  logic [BW-1:0]   b, b_n;
  logic [YW-1:0]   y, y_n;
  logic [GW-1:0]   g, g_n;
  logic [23:0]     rgb0, rgb1;
  logic            accept, last_beat, frame_end;
  assign accept    = aclken & m_axis_video_tvalid & m_axis_video_tready;
  assign last_beat = b == BW'(H_ACTIVE / 2 - 1);
  assign frame_end = accept & last_beat & (y == YW'(V_ACTIVE - 1));
  assign busy      = state != IDLE;
  always_comb begin
    state_n = state;
    g_n = g;
    pat_n = pat;
    solid_n = solid;
    b_n = accept ? (last_beat ? '0 : b + 1'b1) : b;
    y_n = (accept & last_beat) ? (frame_end ? '0 : y + 1'b1) : y;
    if (state == IDLE && enable) state_n = ACTIVE;
    if (state == ACTIVE && frame_end) begin
      state_n = GAP;
      g_n = '0;
    end
    if (state == GAP) begin
      g_n = g + 1'b1;
      if (g == GW'(FRAME_GAP - 1)) state_n = enable ? ACTIVE : IDLE;
    end
    if (state_n == ACTIVE && state != ACTIVE) begin
      pat_n = pattern_t'(pattern_sel);
      solid_n = solid_color;
    end
  end
  // Pixels are generated from next-cycle coordinates so the registered beat lines up with tvalid
  video_pattern_pixel #(.H_ACTIVE(H_ACTIVE)) u_px0 (
    .p(16'({b_n, 1'b0})), .y(16'(y_n)), .pattern(pat_n), .solid_color(solid_n), .rgb(rgb0)
  );
  video_pattern_pixel #(.H_ACTIVE(H_ACTIVE)) u_px1 (
    .p(16'({b_n, 1'b1})), .y(16'(y_n)), .pattern(pat_n), .solid_color(solid_n), .rgb(rgb1)
  );
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state <= IDLE;
      pat <= PAT_BARS;
      solid <= '0;
      b <= '0;
      y <= '0;
      g <= '0;
      frame_count <= '0;
      m_axis_video_tvalid <= 1'b0;
      m_axis_video_tuser <= 1'b0;
      m_axis_video_tlast <= 1'b0;
      m_axis_video_tdata <= '0;
    end else if (aclken) begin
      state <= state_n;
      pat <= pat_n;
      solid <= solid_n;
      b <= b_n;
      y <= y_n;
      g <= g_n;
      if (frame_end) frame_count <= frame_count + 1'b1;
      m_axis_video_tvalid <= state_n == ACTIVE;
      m_axis_video_tuser <= state_n == ACTIVE && b_n == '0 && y_n == '0;
      m_axis_video_tlast <= state_n == ACTIVE && b_n == BW'(H_ACTIVE / 2 - 1);
      m_axis_video_tdata <= state_n == ACTIVE ? {to_pixel(rgb1), to_pixel(rgb0)} : '0;
    end
endmodule

// File: tb/tb_video_pattern_source.sv
// tb_video_pattern_source: directed self-checking bench for video_pattern_source on a 16x4 frame
module tb_video_pattern_source;
  logic        aclk = 1'b0;
  logic        aresetn, aclken, enable, tready;
  logic [1:0]  pattern_sel;
  logic [23:0] solid_color;
  logic [63:0] tdata;
  logic        tvalid, tuser, tlast, busy;
  logic [15:0] frame_count;
  int vectors = 0;
  int miscompares = 0;
  localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                       24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
  always #5 aclk = ~aclk;
  video_pattern_source #(.H_ACTIVE(16), .V_ACTIVE(4), .FRAME_GAP(3)) dut (
    .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .enable(enable),
    .pattern_sel(pattern_sel), .solid_color(solid_color),
    .m_axis_video_tdata(tdata), .m_axis_video_tvalid(tvalid),
    .m_axis_video_tready(tready), .m_axis_video_tuser(tuser),
    .m_axis_video_tlast(tlast), .frame_count(frame_count), .busy(busy)
  );
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [23:0] px(input int pat, input int p, input int y, input logic [23:0] s);
    case (pat)
      0: px = BARS[p * 8 / 16];
      1: px = {3{8'(p)}};
      2: px = ((((p >> 5) ^ (y >> 5)) & 1) != 0) ? 24'hFFFFFF : 24'h000000;
      default: px = s;
    endcase
  endfunction
  function automatic logic [63:0] beat(input int pat, input int b, input int y, input logic [23:0] s);
    return {8'h00, px(pat, 2 * b + 1, y, s), 8'h00, px(pat, 2 * b, y, s)};
  endfunction
  task automatic stream(input int from, input int to, input int pat, input logic [23:0] s);
    tready = 1'b1;
    for (int i = from; i < to; i++) begin
      chk("tvalid", tvalid, 1);
      chk("tdata", tdata, beat(pat, i % 8, i / 8, s));
      chk("tuser", tuser, i == 0);
      chk("tlast", tlast, i % 8 == 7);
      tick();
    end
  endtask
  task automatic gap(input logic resume);
    for (int i = 0; i < 3; i++) begin
      chk("gap_tvalid", tvalid, 0);
      chk("gap_busy", busy, 1);
      tick();
    end
    chk("after_gap_busy", busy, resume);
    chk("after_gap_tvalid", tvalid, resume);
  endtask
  initial begin
    int acc, cyc;
    aresetn = 1'b0; aclken = 1'b1; enable = 1'b0; tready = 1'b0;
    pattern_sel = 2'd0; solid_color = 24'h0;
    tick(); tick();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_fc", frame_count, 0);
    aresetn = 1'b1;
    tick();
    chk("idle_busy", busy, 0);
    // colour bars, continuous ready
    enable = 1'b1; tready = 1'b1;
    tick();
    enable = 1'b0;
    chk("bars_b0", tdata, 64'h00FFFFFF_00FFFFFF);
    stream(0, 32, 0, 0);
    chk("bars_fc", frame_count, 1);
    gap(1'b0);
    // gray ramp with ready toggling every cycle
    pattern_sel = 2'd1; enable = 1'b1;
    tick();
    enable = 1'b0;
    acc = 0; cyc = 0;
    while (acc < 32 && cyc < 200) begin
      tready = (cyc % 2) == 0;
      chk("ramp_tvalid", tvalid, 1);
      chk("ramp_tdata", tdata, beat(1, acc % 8, acc / 8, 0));
      if (acc == 3) chk("ramp_b3", tdata, 64'h00070707_00060606);
      tick();
      if (tready) acc++;
      cyc++;
    end
    chk("ramp_accepted", acc, 32);
    chk("ramp_fc", frame_count, 2);
    gap(1'b0);
    // enable dropped at line 1 beat 2
    pattern_sel = 2'd0; enable = 1'b1;
    tick();
    stream(0, 10, 0, 0);
    enable = 1'b0;
    stream(10, 32, 0, 0);
    chk("drop_fc", frame_count, 3);
    gap(1'b0);
    // asynchronous reset at line 2 beat 5
    enable = 1'b1;
    tick();
    stream(0, 21, 0, 0);
    #2 aresetn = 1'b0;
    #1;
    chk("arst_tvalid", tvalid, 0);
    chk("arst_tdata", tdata, 0);
    chk("arst_tuser", tuser, 0);
    chk("arst_tlast", tlast, 0);
    chk("arst_busy", busy, 0);
    chk("arst_fc", frame_count, 0);
    tick(); tick();
    aresetn = 1'b1;
    tick();
    enable = 1'b0;
    chk("post_rst_tuser", tuser, 1);
    chk("post_rst_tdata", tdata, 64'h00FFFFFF_00FFFFFF);
    stream(0, 32, 0, 0);
    chk("post_rst_fc", frame_count, 1);
    gap(1'b0);
    // clock enable low for 5 cycles mid-line
    pattern_sel = 2'd1; enable = 1'b1;
    tick();
    enable = 1'b0;
    stream(0, 4, 1, 0);
    aclken = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("cen_tvalid", tvalid, 1);
      chk("cen_tdata", tdata, 64'h00090909_00080808);
      chk("cen_tuser", tuser, 0);
      chk("cen_tlast", tlast, 0);
      chk("cen_busy", busy, 1);
      tick();
    end
    aclken = 1'b1;
    stream(4, 32, 1, 0);
    chk("cen_fc", frame_count, 2);
    gap(1'b0);
    // solid held across mid-frame selection change, then checkerboard, frame_count wrap
    force dut.frame_count = 16'hFFFF;
    #1 release dut.frame_count;
    chk("preset_fc", frame_count, 16'hFFFF);
    pattern_sel = 2'd3; solid_color = 24'h123456; enable = 1'b1;
    tick();
    stream(0, 3, 3, 24'h123456);
    pattern_sel = 2'd2; solid_color = 24'hABCDEF;
    stream(3, 32, 3, 24'h123456);
    chk("wrap_fc", frame_count, 0);
    gap(1'b1);
    enable = 1'b0;
    stream(0, 32, 2, 0);
    chk("checker_fc", frame_count, 1);
    gap(1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
